ef_adc8_sar: RTL

EF_ADC8_SAR -- requirements
Module: ef_adc8_sar

---
 rtl/ef_adc8_sar.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/ef_adc8_sar.sv
// ef_adc8_sar: 8-bit successive-approximation ADC controller.
// Drives an external DAC code and sample/hold switch, reads an external
// comparator, and binary-searches the input over 8 bit decisions.
// Timeline from the START edge: one entry cycle plus SAMPLE_CYCLES track
// cycles, then 8 bit trials of T = CFG+1 cycles each, then one VALID cycle.
module ef_adc8_sar #(
    parameter int NoConfigBits  = 2,
    parameter int SAMPLE_CYCLES = 4
) (
    input  logic                    UserCLK,
    input  logic                    RESET,
    input  logic                    START,
    output logic [7:0]              DATA,
    output logic                    VALID,
    output logic                    BUSY,
    output logic [7:0]              DAC_top,
    output logic                    HOLD_top,
    input  logic                    CMP_top,
    input  logic [NoConfigBits-1:0] ConfigBits
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_CONVERT
    } state_t;

    localparam logic [3:0] SAMPLE_LAST = 4'(SAMPLE_CYCLES);

    state_t     r_state, w_state_next;
    logic [3:0] r_cnt, w_cnt_next;          // track-phase counter
    logic [1:0] r_settle, w_settle_next;    // cycles spent on current trial
    logic [1:0] r_cfg, w_cfg_next;          // settle setting frozen for this conversion
    logic [2:0] r_bit, w_bit_next;          // bit under test
    logic [7:0] r_trial, w_trial_next;      // code presented to the DAC
    logic [7:0] r_data, w_data_next;
    logic       r_valid, w_valid_next;
    logic       r_busy, w_busy_next;
    logic       r_hold, w_hold_next;

    logic [2:0] w_bit_dn;
    logic [7:0] w_decided;                  // trial with the current bit resolved by the comparator
    logic [7:0] w_trial_step;               // resolved code with the next lower bit set as the new trial

    assign w_bit_dn = r_bit - 3'd1;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            assign w_decided[gi]    = (r_bit == 3'(gi)) ? CMP_top : r_trial[gi];
            assign w_trial_step[gi] = (w_bit_dn == 3'(gi)) ? 1'b1 : w_decided[gi];
        end
    endgenerate

    // State and output registers; reset aborts any conversion immediately.
    always_ff @(posedge UserCLK or posedge RESET) begin
        if (RESET) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_settle <= 2'd0;
            r_cfg    <= 2'd0;
            r_bit    <= 3'd0;
            r_trial  <= 8'h00;
            r_data   <= 8'h00;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_hold   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_settle <= w_settle_next;
            r_cfg    <= w_cfg_next;
            r_bit    <= w_bit_next;
            r_trial  <= w_trial_next;
            r_data   <= w_data_next;
            r_valid  <= w_valid_next;
            r_busy   <= w_busy_next;
            r_hold   <= w_hold_next;
        end
    end

    // Next-state and next-output logic for the IDLE/SAMPLE/CONVERT sequence.
    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_settle_next = r_settle;
        w_cfg_next    = r_cfg;
        w_bit_next    = r_bit;
        w_trial_next  = r_trial;
        w_data_next   = r_data;
        w_valid_next  = 1'b0;
        w_busy_next   = r_busy;
        w_hold_next   = r_hold;

        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_state_next = ST_SAMPLE;
                    w_busy_next  = 1'b1;
                    w_hold_next  = 1'b0;
                    w_trial_next = 8'h00;
                    w_cnt_next   = 4'd0;
                end
            end
            ST_SAMPLE: begin
                if (r_cnt == SAMPLE_LAST) begin
                    // Track window over: hold the input and present the MSB trial.
                    w_state_next  = ST_CONVERT;
                    w_hold_next   = 1'b1;
                    w_bit_next    = 3'd7;
                    w_trial_next  = 8'h80;
                    w_cfg_next    = ConfigBits[1:0];
                    w_settle_next = 2'd0;
                    w_cnt_next    = 4'd0;
                end else begin
                    w_cnt_next = r_cnt + 4'd1;
                end
            end
            ST_CONVERT: begin
                if (r_settle == r_cfg) begin
                    if (r_bit == 3'd0) begin
                        // Last decision: publish the result and release the hold.
                        w_state_next = ST_IDLE;
                        w_trial_next = w_decided;
                        w_data_next  = w_decided;
                        w_valid_next = 1'b1;
                        w_busy_next  = 1'b0;
                        w_hold_next  = 1'b0;
                    end else begin
                        w_trial_next = w_trial_step;
                        w_bit_next   = w_bit_dn;
                    end
                    w_settle_next = 2'd0;
                end else begin
                    w_settle_next = r_settle + 2'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign DATA     = r_data;
    assign VALID    = r_valid;
    assign BUSY     = r_busy;
    assign DAC_top  = r_trial;
    assign HOLD_top = r_hold;

endmodule
